// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter / next-PC stage.
package pc_sequencer_pkg;

  localparam logic [4:0] LINK_REG = 5'd31;

  // Bit positions inside the {N,Z,V} status-flag register.
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JUMP   = 2'd2,
    JSPAL  = 2'd3
  } next_pc_sel_e;

  // Clears the two low address bits so any fetched target is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder/datapath <-> PC stage signal bundle. The master side is the
// control decoder and datapath; the slave side is the PC sequencer.
interface pc_sequencer_if;

  logic        stall;
  logic        branch;
  logic        jump;
  logic        bltzal;
  logic        jspal;
  logic        baln;
  logic        alu_zero;
  logic [31:0] rs_value;
  logic [31:0] imm_sext;
  logic [25:0] jtarget;
  logic [31:0] mem_rdata;
  logic        flag_we;
  logic        alu_n;
  logic        alu_z;
  logic        alu_v;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [2:0]  flags;
  logic        link_we;
  logic [4:0]  link_addr;
  logic [31:0] link_data;
  logic [31:0] retired;

  modport master (
    output stall, branch, jump, bltzal, jspal, baln, alu_zero,
           rs_value, imm_sext, jtarget, mem_rdata,
           flag_we, alu_n, alu_z, alu_v,
    input  pc, pc_plus4, flags, link_we, link_addr, link_data, retired
  );

  modport slave (
    input  stall, branch, jump, bltzal, jspal, baln, alu_zero,
           rs_value, imm_sext, jtarget, mem_rdata,
           flag_we, alu_n, alu_z, alu_v,
    output pc, pc_plus4, flags, link_we, link_addr, link_data, retired
  );

endinterface

// File: rtl/pc_sequencer_next_pc_mux.sv
// Combinational branch/jump target generation and next-PC priority select.
// Priority is defensive: the decoder should only ever raise one strobe.
module next_pc_mux
  import pc_sequencer_pkg::*;
(
  input  logic [31:0]  pc_plus4_i,
  input  logic [31:0]  imm_sext_i,
  input  logic [25:0]  jtarget_i,
  input  logic [31:0]  mem_rdata_i,
  input  logic [31:0]  rs_value_i,
  input  logic         branch_i,
  input  logic         jump_i,
  input  logic         bltzal_i,
  input  logic         jspal_i,
  input  logic         baln_i,
  input  logic         alu_zero_i,
  input  logic         flag_n_i,
  output next_pc_sel_e sel_o,
  output logic [31:0]  next_pc_o
);

  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] jspal_tgt;
  logic        rs_negative;
  logic        branch_taken;

  // Target arithmetic wraps modulo 2^32 with no overflow indication.
  always_comb begin
    branch_tgt   = pc_plus4_i + (imm_sext_i << 2);
    jump_tgt     = {pc_plus4_i[31:28], jtarget_i, 2'b00};
    jspal_tgt    = word_align(mem_rdata_i);
    rs_negative  = $signed(rs_value_i) < 0;
    branch_taken = (baln_i & flag_n_i) | (bltzal_i & rs_negative) | (branch_i & alu_zero_i);
  end

  // Priority: jspal, jump, then any taken conditional branch, else sequential.
  always_comb begin
    sel_o     = SEQ;
    next_pc_o = pc_plus4_i;
    if (jspal_i) begin
      sel_o     = JSPAL;
      next_pc_o = jspal_tgt;
    end else if (jump_i) begin
      sel_o     = JUMP;
      next_pc_o = jump_tgt;
    end else if (branch_taken) begin
      sel_o     = BRANCH;
      next_pc_o = branch_tgt;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register, N/Z/V flag register, retired-instruction counter and $31 link
// write for the single-cycle datapath. The next PC is chosen combinationally
// and registered on the same edge, so there is no delay slot.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk_i,
  input  logic          reset_i,
  pc_sequencer_if.slave bus
);

  logic [31:0]  pc_q, pc_d;
  logic [2:0]   flags_q, flags_d;
  logic [31:0]  retired_q, retired_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  mux_next_pc;
  next_pc_sel_e mux_sel;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_mux u_next_pc_mux (
    .pc_plus4_i  (pc_plus4),
    .imm_sext_i  (bus.imm_sext),
    .jtarget_i   (bus.jtarget),
    .mem_rdata_i (bus.mem_rdata),
    .rs_value_i  (bus.rs_value),
    .branch_i    (bus.branch),
    .jump_i      (bus.jump),
    .bltzal_i    (bus.bltzal),
    .jspal_i     (bus.jspal),
    .baln_i      (bus.baln),
    .alu_zero_i  (bus.alu_zero),
    .flag_n_i    (flags_q[FLAG_N]),
    .sel_o       (mux_sel),
    .next_pc_o   (mux_next_pc)
  );

  // Next-state values; a stall freezes PC, flags and the retired counter.
  // baln samples the registered N, so a coinciding flag write is not seen.
  always_comb begin
    pc_d      = pc_q;
    flags_d   = flags_q;
    retired_d = retired_q;
    if (!bus.stall) begin
      pc_d      = (mux_sel == SEQ) ? pc_plus4 : mux_next_pc;
      retired_d = retired_q + 32'd1;
      if (bus.flag_we) begin
        flags_d[FLAG_N] = bus.alu_n;
        flags_d[FLAG_Z] = bus.alu_z;
        flags_d[FLAG_V] = bus.alu_v;
      end
    end
  end

  // State registers; reset overrides stall and every strobe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q      <= RESET_PC;
      flags_q   <= 3'b000;
      retired_q <= 32'd0;
    end else begin
      pc_q      <= pc_d;
      flags_q   <= flags_d;
      retired_q <= retired_d;
    end
  end

  // Link write is combinational so the register file commits $31 on the
  // same edge the PC advances; baln links only when actually taken.
  always_comb begin
    bus.link_we = !bus.stall &
                  (bus.jspal | bus.bltzal | (bus.baln & flags_q[FLAG_N]));
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.flags     = flags_q;
  assign bus.link_addr = LINK_REG;
  assign bus.link_data = pc_plus4;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized checks of pc_sequencer against a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk;
  logic reset;
  int   vecs;
  int   errs;

  logic [31:0] m_pc;
  logic [2:0]  m_flags;
  logic [31:0] m_ret;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.stall     = 1'b0;
    bus.branch    = 1'b0;
    bus.jump      = 1'b0;
    bus.bltzal    = 1'b0;
    bus.jspal     = 1'b0;
    bus.baln      = 1'b0;
    bus.alu_zero  = 1'b0;
    bus.rs_value  = 32'd0;
    bus.imm_sext  = 32'd0;
    bus.jtarget   = 26'd0;
    bus.mem_rdata = 32'd0;
    bus.flag_we   = 1'b0;
    bus.alu_n     = 1'b0;
    bus.alu_z     = 1'b0;
    bus.alu_v     = 1'b0;
  endtask

  // Instruction-level meaning of the strobes, straight from the ISA rules.
  function automatic logic [31:0] model_next_pc();
    logic [31:0] seq;
    logic [31:0] off;
    seq = m_pc + 32'd4;
    off = bus.imm_sext * 32'd4;
    if (bus.jspal)                         return {bus.mem_rdata[31:2], 2'b00};
    if (bus.jump)                          return {seq[31:28], bus.jtarget, 2'b00};
    if (bus.baln && m_flags[2])            return seq + off;
    if (bus.bltzal && bus.rs_value[31])    return seq + off;
    if (bus.branch && bus.alu_zero)        return seq + off;
    return seq;
  endfunction

  // Called at posedge+1 with inputs already applied: checks outputs mid-cycle,
  // advances the model, then crosses one rising edge.
  task automatic step();
    logic [31:0] nxt;
    logic        lwe;
    #3;
    lwe = !bus.stall && (bus.jspal || bus.bltzal || (bus.baln && m_flags[2]));
    chk("pc",        bus.pc,        m_pc);
    chk("pc_plus4",  bus.pc_plus4,  m_pc + 32'd4);
    chk("link_data", bus.link_data, m_pc + 32'd4);
    chk("link_addr", {27'd0, bus.link_addr}, 32'd31);
    chk("link_we",   {31'd0, bus.link_we},   {31'd0, lwe});
    chk("flags",     {29'd0, bus.flags},     {29'd0, m_flags});
    chk("retired",   bus.retired,   m_ret);
    nxt = model_next_pc();
    if (reset) begin
      m_pc    = RST_PC;
      m_flags = 3'b000;
      m_ret   = 32'd0;
    end else if (!bus.stall) begin
      m_pc  = nxt;
      m_ret = m_ret + 32'd1;
      if (bus.flag_we) m_flags = {bus.alu_n, bus.alu_z, bus.alu_v};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] target);
    idle();
    bus.jspal     = 1'b1;
    bus.mem_rdata = target;
    step();
    idle();
  endtask

  initial begin
    int k;
    vecs    = 0;
    errs    = 0;
    m_pc    = RST_PC;
    m_flags = 3'b000;
    m_ret   = 32'd0;
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset values, then three idle cycles.
    step();
    chk("rst_pc", bus.pc, 32'h0040_0000);
    chk("rst_flags", {29'd0, bus.flags}, 32'd0);
    chk("rst_retired", bus.retired, 32'd0);
    reset = 1'b0;
    step(); step(); step();
    chk("idle3_pc", bus.pc, 32'h0040_000C);
    chk("idle3_retired", bus.retired, 32'd3);

    // beq taken / not taken.
    goto_pc(32'h100);
    bus.branch = 1'b1; bus.alu_zero = 1'b1; bus.imm_sext = 32'hFFFF_FFFE;
    step();
    chk("beq_taken", bus.pc, 32'h0FC);
    goto_pc(32'h100);
    bus.branch = 1'b1; bus.alu_zero = 1'b0; bus.imm_sext = 32'hFFFF_FFFE;
    step();
    chk("beq_not_taken", bus.pc, 32'h104);

    // bltzal taken / not taken; both link.
    goto_pc(32'h200);
    bus.bltzal = 1'b1; bus.rs_value = 32'h8000_0000; bus.imm_sext = 32'd4;
    #3;
    chk("bltzal_link_we", {31'd0, bus.link_we}, 32'd1);
    chk("bltzal_link_data", bus.link_data, 32'h204);
    #(-0) step();
    chk("bltzal_taken", bus.pc, 32'h214);
    goto_pc(32'h200);
    bus.bltzal = 1'b1; bus.rs_value = 32'd5; bus.imm_sext = 32'd4;
    step();
    chk("bltzal_not_taken", bus.pc, 32'h204);

    // baln reads registered N even while flags are being rewritten.
    goto_pc(32'h300);
    bus.flag_we = 1'b1; bus.alu_n = 1'b1;
    step();
    idle();
    bus.baln = 1'b1; bus.flag_we = 1'b1; bus.alu_n = 1'b0; bus.imm_sext = 32'h10;
    step();
    chk("baln_old_n_taken", bus.pc, 32'h308 + 32'h40);
    chk("baln_flag_n_cleared", {31'd0, bus.flags[2]}, 32'd0);
    idle();
    bus.baln = 1'b1; bus.imm_sext = 32'h10;
    step();
    chk("baln_not_taken", bus.pc, 32'h34C);

    // jspal alignment and jump region.
    goto_pc(32'h0000_1237);
    chk("jspal_align", bus.pc, 32'h0000_1234);
    goto_pc(32'h3000_0010);
    bus.jump = 1'b1; bus.jtarget = 26'h10;
    step();
    chk("jump_target", bus.pc, 32'h3000_0040);

    // Stall with jump held: nothing moves.
    idle();
    bus.stall = 1'b1; bus.jump = 1'b1; bus.jspal = 1'b1; bus.jtarget = 26'h3FF;
    step();
    chk("stall_pc", bus.pc, 32'h3000_0040);

    // Sequential wrap of the PC.
    goto_pc(32'hFFFF_FFFC);
    step();
    chk("pc_wrap", bus.pc, 32'h0);

    // Retired counter wrap.
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    m_ret = 32'hFFFF_FFFF;
    step();
    chk("retired_wrap", bus.retired, 32'd0);

    // Mid-run reset beats a pending branch and a stall.
    idle();
    reset = 1'b1; bus.jump = 1'b1; bus.jtarget = 26'h123; bus.stall = 1'b1;
    step();
    chk("reset_midrun_pc", bus.pc, RST_PC);
    reset = 1'b0;
    idle();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      reset         = ($urandom_range(0, 99) < 3);
      bus.stall     = ($urandom_range(0, 3) == 0);
      bus.alu_zero  = $urandom_range(0, 1) == 1;
      bus.rs_value  = $urandom;
      bus.imm_sext  = $urandom_range(0, 1) == 1 ? 32'hFFFF_0000 | $urandom_range(0, 16'hFFFF)
                                                : 32'(unsigned'($urandom_range(0, 16'hFFFF)));
      bus.jtarget   = 26'($urandom);
      bus.mem_rdata = $urandom;
      bus.flag_we   = $urandom_range(0, 1) == 1;
      bus.alu_n     = $urandom_range(0, 1) == 1;
      bus.alu_z     = $urandom_range(0, 1) == 1;
      bus.alu_v     = $urandom_range(0, 1) == 1;
      k = reset ? 0 : int'($urandom_range(0, 5));
      case (k)
        1: bus.branch = 1'b1;
        2: bus.jump   = 1'b1;
        3: bus.bltzal = 1'b1;
        4: bus.jspal  = 1'b1;
        5: bus.baln   = 1'b1;
        default: ;
      endcase
      step();
    end
    reset = 1'b0;
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
